// File: rtl/if_stage_queue_pkg.sv
// Shared constants for the IF/ID fetch queue: default word width, depth and bubble value.
package if_stage_queue_pkg;

  localparam int   IFQ_WORD_WIDTH = 32;
  localparam int   IFQ_DEPTH      = 4;
  // An empty queue presents all-zero PC/instruction to ID, i.e. a NOP bubble.
  localparam logic BUBBLE_BIT     = 1'b0;

  function automatic logic [IFQ_WORD_WIDTH-1:0] ifq_bubble();
    return {IFQ_WORD_WIDTH{BUBBLE_BIT}};
  endfunction

endpackage

// File: rtl/if_queue_storage.sv
// Unreset DEPTH x WIDTH register array for the fetch queue.
// One synchronous write port, one combinational read port.
module if_queue_storage #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_stage_queue.sv
// In-order {PC, instruction} queue between IF and ID; flush empties it in one cycle.
// Optional macro IF_QUEUE_BYPASS_EN adds a 0-cycle empty-queue bypass from IF to ID.
module if_stage_queue
  import if_stage_queue_pkg::*;
#(
  parameter  int WORD_WIDTH = IFQ_WORD_WIDTH,
  parameter  int DEPTH      = IFQ_DEPTH,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Flush,
  input  logic                  Freeze,
  input  logic                  valid_in,
  input  logic [WORD_WIDTH-1:0] PC_in,
  input  logic [WORD_WIDTH-1:0] instruction_in,
  output logic                  full,
  output logic                  valid_out,
  output logic [WORD_WIDTH-1:0] PC_out,
  output logic [WORD_WIDTH-1:0] instruction_out,
  output logic [PTR_W:0]        count
);

  localparam logic [PTR_W:0]        CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]        CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [WORD_WIDTH-1:0] BUBBLE   = {WORD_WIDTH{BUBBLE_BIT}};

  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]          count_q, count_d;
  logic [2*WORD_WIDTH-1:0] rdata;
  logic                    q_valid, q_full;
  logic                    push, pop, we;
  logic                    byp_consume;

  assign q_valid = (count_q != '0);
  assign q_full  = (count_q == CNT_FULL);

  // Blocking push on full regardless of pop keeps full independent of Freeze.
  assign push = valid_in & ~q_full;
  assign pop  = q_valid & ~Freeze;

`ifdef IF_QUEUE_BYPASS_EN
  logic byp;
  assign byp         = ~q_valid & valid_in & rst & ~Flush;
  assign byp_consume = byp & ~Freeze;
`else
  assign byp_consume = 1'b0;
`endif

  assign we = push & ~byp_consume & ~Flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (we)  wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({we, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  if_queue_storage #(
    .WIDTH (2*WORD_WIDTH),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata ({PC_in, instruction_in}),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    valid_out       = q_valid;
    PC_out          = BUBBLE;
    instruction_out = BUBBLE;
    if (q_valid) begin
      PC_out          = rdata[2*WORD_WIDTH-1:WORD_WIDTH];
      instruction_out = rdata[WORD_WIDTH-1:0];
    end
`ifdef IF_QUEUE_BYPASS_EN
    else if (byp) begin
      valid_out       = 1'b1;
      PC_out          = PC_in;
      instruction_out = instruction_in;
    end
`endif
  end

  assign full  = q_full;
  assign count = count_q;

endmodule

// File: tb/tb_if_stage_queue.sv
// Directed self-checking bench for if_stage_queue (DEPTH=4, WORD_WIDTH=32).
module tb_if_stage_queue;

  logic        clk;
  logic        rst;
  logic        Flush;
  logic        Freeze;
  logic        valid_in;
  logic [31:0] PC_in;
  logic [31:0] instruction_in;
  logic        full;
  logic        valid_out;
  logic [31:0] PC_out;
  logic [31:0] instruction_out;
  logic [2:0]  count;

  int checks;
  int failures;

  if_stage_queue dut (
    .clk             (clk),
    .rst             (rst),
    .Flush           (Flush),
    .Freeze          (Freeze),
    .valid_in        (valid_in),
    .PC_in           (PC_in),
    .instruction_in  (instruction_in),
    .full            (full),
    .valid_out       (valid_out),
    .PC_out          (PC_out),
    .instruction_out (instruction_out),
    .count           (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return 32'hA500_0000 ^ pc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    valid_in       = v;
    PC_in          = pc;
    instruction_in = ins_of(pc);
  endtask

  task automatic test_reset();
    rst = 1'b0; Flush = 1'b0; Freeze = 1'b0;
    drive(1'b1, 32'h100);
    tick();
    tick();
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (PC_out !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", PC_out); end
    checks++; if (instruction_out !== 32'h0) begin failures++; $display("FAIL reset_ins got=%h exp=0", instruction_out); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    drive(1'b0, 32'h0);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fill_freeze();
    Freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4*i));
      tick();
      checks++;
      if (count !== 3'(i+1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i+1); end
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
    drive(1'b1, 32'h10);
    tick();
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_fifth_count got=%0d exp=4", count); end
    checks++; if (PC_out !== 32'h0) begin failures++; $display("FAIL fill_head_pc got=%h exp=0", PC_out); end
    checks++; if (instruction_out !== ins_of(32'h0)) begin failures++; $display("FAIL fill_head_ins got=%h exp=%h", instruction_out, ins_of(32'h0)); end
    drive(1'b0, 32'h0);
  endtask

  task automatic test_drain();
    Freeze = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid_out !== 1'b1 || PC_out !== 32'(4*i)) begin
        failures++; $display("FAIL drain_head[%0d] got v=%b pc=%h exp v=1 pc=%h", i, valid_out, PC_out, 4*i);
      end
      tick();
    end
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL drain_empty_valid got=%b exp=0", valid_out); end
    checks++; if (PC_out !== 32'h0) begin failures++; $display("FAIL drain_empty_pc got=%h exp=0", PC_out); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL drain_empty_count got=%0d exp=0", count); end
  endtask

  // Reference queue tracks what ID should see each cycle while Freeze toggles.
  task automatic test_wrap();
    logic [31:0] model[$];
    logic [31:0] exp_pc;
    int sent, recv, cyc;
    logic push_e, pop_e, exp_v;
    sent = 0; recv = 0; cyc = 0;
    while ((recv < 10) && (cyc < 60)) begin
      Freeze = (cyc % 2 == 0);
      drive(sent < 10, 32'h200 + 32'(4*sent));
      #1;
      exp_v  = (model.size() != 0);
      exp_pc = exp_v ? model[0] : 32'h0;
      push_e = valid_in && (model.size() < 4);
      pop_e  = exp_v && !Freeze;
`ifdef IF_QUEUE_BYPASS_EN
      if (!exp_v && valid_in) begin
        exp_v  = 1'b1;
        exp_pc = PC_in;
        if (!Freeze) begin
          push_e = 1'b0;
          pop_e  = 1'b1;
          model.push_back(PC_in);
        end
      end
`endif
      checks++;
      if (valid_out !== exp_v || PC_out !== exp_pc) begin
        failures++; $display("FAIL wrap_head cyc=%0d got v=%b pc=%h exp v=%b pc=%h", cyc, valid_out, PC_out, exp_v, exp_pc);
      end
      if (pop_e) begin
        void'(model.pop_front());
        recv++;
      end
      if (push_e) begin
        model.push_back(PC_in);
        sent++;
      end
      tick();
      checks++;
      if (count !== 3'(model.size()) || count > 3'd4) begin
        failures++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", cyc, count, model.size());
      end
      cyc++;
    end
    checks++;
    if (recv != 10) begin failures++; $display("FAIL wrap_timeout got=%0d exp=10 entries", recv); end
    drive(1'b0, 32'h0);
    Freeze = 1'b0;
  endtask

  task automatic test_flush();
    Freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h30 + 32'(4*i));
      tick();
    end
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
    Flush = 1'b1;
    drive(1'b1, 32'h40);
    tick();
    Flush = 1'b0;
    drive(1'b0, 32'h0);
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (valid_out !== 1'b0 || PC_out !== 32'h0) begin failures++; $display("FAIL flush_out got v=%b pc=%h exp v=0 pc=0", valid_out, PC_out); end
    Freeze = 1'b0;
    tick();
    checks++; if (valid_out !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL flush_absent got v=%b cnt=%0d exp v=0 cnt=0", valid_out, count); end
  endtask

  task automatic test_push_pop();
    Freeze = 1'b1;
    drive(1'b1, 32'h50); tick();
    drive(1'b1, 32'h54); tick();
    Freeze = 1'b0;
    drive(1'b1, 32'h58);
    #1;
    checks++; if (PC_out !== 32'h50) begin failures++; $display("FAIL pp_head got=%h exp=50", PC_out); end
    tick();
    drive(1'b0, 32'h0);
    #1;
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL pp_count got=%0d exp=2", count); end
    checks++; if (PC_out !== 32'h54) begin failures++; $display("FAIL pp_next got=%h exp=54", PC_out); end
    tick();
    checks++; if (PC_out !== 32'h58 || instruction_out !== ins_of(32'h58)) begin failures++; $display("FAIL pp_last got pc=%h ins=%h exp pc=58 ins=%h", PC_out, instruction_out, ins_of(32'h58)); end
    tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL pp_drained got=%0d exp=0", count); end
  endtask

  task automatic test_full_pop();
    Freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h60 + 32'(4*i));
      tick();
    end
    Freeze = 1'b0;
    drive(1'b1, 32'h70);
    tick();
    drive(1'b0, 32'h0);
    #1;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL fullpop_count got=%0d exp=3", count); end
    checks++; if (full !== 1'b0 || PC_out !== 32'h64) begin failures++; $display("FAIL fullpop_head got full=%b pc=%h exp full=0 pc=64", full, PC_out); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || valid_out !== 1'b0) begin failures++; $display("FAIL midreset got cnt=%0d v=%b exp cnt=0 v=0", count, valid_out); end
  endtask

`ifdef IF_QUEUE_BYPASS_EN
  task automatic test_bypass();
    Freeze = 1'b0;
    drive(1'b1, 32'h80);
    #1;
    checks++; if (valid_out !== 1'b1 || PC_out !== 32'h80) begin failures++; $display("FAIL byp_same got v=%b pc=%h exp v=1 pc=80", valid_out, PC_out); end
    tick();
    drive(1'b0, 32'h0);
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL byp_count got=%0d exp=0", count); end
    Freeze = 1'b1;
    drive(1'b1, 32'h84);
    tick();
    drive(1'b0, 32'h0);
    #1;
    checks++; if (count !== 3'd1 || PC_out !== 32'h84) begin failures++; $display("FAIL byp_frozen got cnt=%0d pc=%h exp cnt=1 pc=84", count, PC_out); end
    Freeze = 1'b0;
    tick();
    Flush = 1'b1;
    drive(1'b1, 32'h88);
    #1;
    checks++; if (valid_out !== 1'b0 || PC_out !== 32'h0) begin failures++; $display("FAIL byp_flush got v=%b pc=%h exp v=0 pc=0", valid_out, PC_out); end
    tick();
    Flush = 1'b0;
    drive(1'b0, 32'h0);
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0; Flush = 1'b0; Freeze = 1'b0;
    valid_in = 1'b0; PC_in = '0; instruction_in = '0;
    test_reset();
    test_fill_freeze();
    test_drain();
    test_wrap();
    test_flush();
    test_push_pop();
    test_full_pop();
`ifdef IF_QUEUE_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
